// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      Instruction,
    input  logic             zero,
    input  logic             greater_than,
    input  logic             mem_ready,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             branch,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic             MemtoReg,
    output logic             MemWrite,
    output logic             MemRead,
    output logic             z,
    output logic             g,
    output logic             lui,
    output logic [2:0]       ALUControl,
    output logic             pc_en,
    output logic             ir_en,
    output logic             busy,
    output logic             halted,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] retired_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ECALL   = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    logic [2:0] state;
    logic [6:0] opc;
    logic [2:0] f3;
    logic       f7b5;
    logic [7:0] tmo_cnt;

    logic is_r, is_i, is_ld, is_st, is_br, is_lui, is_ecall, illegal;
    logic [2:0] alu_dec, alu_sel;

    logic unused_instr_bits;
    assign unused_instr_bits = ^{Instruction[31], Instruction[29:15], Instruction[11:7]};

    assign is_r     = (opc == OP_R);
    assign is_i     = (opc == OP_I);
    assign is_ld    = (opc == OP_LD);
    assign is_st    = (opc == OP_ST);
    assign is_br    = (opc == OP_BR);
    assign is_lui   = (opc == OP_LUI);
    assign is_ecall = (opc == OP_ECALL);

    // funct3 011 has no ALU mapping, so it makes an R/I instruction illegal
    assign illegal = !(is_r || is_i || is_ld || is_st || is_br || is_lui || is_ecall)
                   || ((is_r || is_i) && (f3 == 3'b011));

    always_comb begin
        alu_dec = ALU_ADD;
        case (f3)
            3'b000:  alu_dec = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_dec = ALU_AND;
            3'b110:  alu_dec = ALU_OR;
            3'b100:  alu_dec = ALU_XOR;
            3'b010:  alu_dec = ALU_SLT;
            3'b001:  alu_dec = ALU_SLL;
            3'b101:  alu_dec = ALU_SRL;
            default: alu_dec = ALU_ADD;
        endcase
    end

    assign alu_sel = is_br ? ALU_SUB : ((is_r || is_i) ? alu_dec : ALU_ADD);

    always_comb begin
        PCSrc      = 1'b0;
        RegWrite   = 1'b0;
        branch     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 1'b0;
        MemtoReg   = 1'b0;
        MemWrite   = 1'b0;
        MemRead    = 1'b0;
        z          = 1'b0;
        g          = 1'b0;
        lui        = 1'b0;
        ALUControl = ALU_ADD;
        pc_en      = 1'b0;
        ir_en      = 1'b0;
        // ALU steering stays asserted from EXEC through MEM and WB
        if (state == S_EXEC || state == S_MEM || state == S_WB) begin
            ALUSrcA    = is_r || is_i || is_ld || is_st || is_br;
            ALUSrcB    = is_i || is_ld || is_st;
            ALUControl = alu_sel;
            lui        = is_lui;
        end
        case (state)
            S_FETCH: ir_en = 1'b1;
            S_EXEC: begin
                if (is_br) begin
                    branch = 1'b1;
                    z      = (f3 == 3'b000);
                    g      = (f3 == 3'b101);
                    PCSrc  = ((f3 == 3'b000) && zero) || ((f3 == 3'b101) && greater_than);
                    pc_en  = 1'b1;
                end
            end
            S_MEM: begin
                MemRead  = is_ld;
                MemWrite = is_st;
                pc_en    = is_st && mem_ready;
            end
            S_WB: begin
                RegWrite = 1'b1;
                MemtoReg = is_ld;
                pc_en    = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy   = (state != S_IDLE) && (state != S_HALT);
    assign halted = (state == S_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            opc           <= 7'd0;
            f3            <= 3'd0;
            f7b5          <= 1'b0;
            tmo_cnt       <= 8'd0;
            err_code      <= ERR_NONE;
            retired_count <= '0;
        end else begin
            if (pc_en) retired_count <= retired_count + CNT_W'(1);
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        err_code <= ERR_NONE;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    opc   <= Instruction[6:0];
                    f3    <= Instruction[14:12];
                    f7b5  <= Instruction[30];
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    if (illegal) begin
                        err_code <= ERR_ILLEGAL;
                        state    <= S_HALT;
                    end else if (is_ecall) begin
                        err_code <= ERR_ECALL;
                        state    <= S_HALT;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_br) begin
                        state <= S_FETCH;
                    end else if (is_ld || is_st) begin
                        tmo_cnt <= 8'd0;
                        state   <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state <= is_ld ? S_WB : S_FETCH;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_code <= ERR_TIMEOUT;
                        state    <= S_HALT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_WB:    state <= S_FETCH;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic       clk, rst, start, zero, greater_than, mem_ready;
    logic [31:0] Instruction;
    logic PCSrc, RegWrite, branch, ALUSrcA, ALUSrcB, MemtoReg, MemWrite, MemRead, z, g, lui;
    logic [2:0] ALUControl;
    logic pc_en, ir_en, busy, halted;
    logic [1:0] err_code;
    logic [2:0] retired_count;

    int checks = 0;
    int errors = 0;
    int row    = -1;
    int exp_ret = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .Instruction(Instruction),
        .zero(zero), .greater_than(greater_than), .mem_ready(mem_ready),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .branch(branch), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .MemRead(MemRead),
        .z(z), .g(g), .lui(lui), .ALUControl(ALUControl), .pc_en(pc_en), .ir_en(ir_en),
        .busy(busy), .halted(halted), .err_code(err_code), .retired_count(retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        int zero; int gt; int waits; int cyc;
        int alu; int sa; int sb; int lu; int br; int zz; int gg; int pcsrc;
        int rw_cyc; int m2r; int mrd; int mwr; int err;
    } vec_t;

    vec_t v[21];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
        end
    endtask

    task automatic run_row(input vec_t t);
        int cyc = 0, memcnt = 0, mrd = 0, mwr = 0, rw_cyc = 0, m2r = 0, pce = 0, ire = 0;
        int alu_c = 0, sa_c = 0, sb_c = 0, lu_c = 0, br_c = 0, z_c = 0, g_c = 0, ps_c = 0, hlt = 0;
        bit done = 0;
        Instruction  = t.ins;
        zero         = (t.zero != 0);
        greater_than = (t.gt != 0);
        for (int k = 0; k < 30 && !done; k++) begin
            cyc++;
            if (MemRead || MemWrite) begin
                mem_ready = (memcnt >= t.waits);
                memcnt++;
            end else begin
                mem_ready = 1'b0;
            end
            #1;
            mrd += int'(MemRead);
            mwr += int'(MemWrite);
            ire += int'(ir_en);
            pce += int'(pc_en);
            if (RegWrite) rw_cyc = cyc;
            if (MemtoReg) m2r = 1;
            if (cyc == 3) begin
                alu_c = int'(ALUControl); sa_c = int'(ALUSrcA); sb_c = int'(ALUSrcB);
                lu_c = int'(lui); br_c = int'(branch); z_c = int'(z); g_c = int'(g);
                ps_c = int'(PCSrc);
            end
            if (pc_en || halted) begin
                done = 1;
                hlt  = int'(halted);
            end
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        check("completion", int'(done), 1);
        check("cycles", cyc, t.cyc);
        check("ir_en_count", ire, 1);
        check("alu_control", alu_c, t.alu);
        check("alu_src_a", sa_c, t.sa);
        check("alu_src_b", sb_c, t.sb);
        check("lui", lu_c, t.lu);
        check("branch", br_c, t.br);
        check("z", z_c, t.zz);
        check("g", g_c, t.gg);
        check("pcsrc", ps_c, t.pcsrc);
        check("regwrite_cycle", rw_cyc, t.rw_cyc);
        check("memtoreg", m2r, t.m2r);
        check("memread_cycles", mrd, t.mrd);
        check("memwrite_cycles", mwr, t.mwr);
        check("pc_en_count", pce, (t.err == 0) ? 1 : 0);
        check("halted", hlt, (t.err != 0) ? 1 : 0);
        check("err_code", int'(err_code), t.err);
        if (t.err == 0) exp_ret++;
        check("retired_count", int'(retired_count), exp_ret % 8);
    endtask

    initial begin
        // ins, zero, gt, waits, cyc, alu, sa, sb, lui, br, z, g, pcsrc, rw_cyc, m2r, mrd, mwr, err
        v[0]  = '{32'h40000033, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0};
        v[1]  = '{32'h00000033, 0, 0, 0, 4, 0, 1, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0};
        v[2]  = '{32'h00007033, 0, 0, 0, 4, 2, 1, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0};
        v[3]  = '{32'h00002033, 0, 0, 0, 4, 5, 1, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0};
        v[4]  = '{32'h00005033, 0, 0, 0, 4, 7, 1, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0};
        v[5]  = '{32'h40000013, 0, 0, 0, 4, 0, 1, 1, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0};
        v[6]  = '{32'h00006013, 0, 0, 0, 4, 3, 1, 1, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0};
        v[7]  = '{32'h00004013, 0, 0, 0, 4, 4, 1, 1, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0};
        v[8]  = '{32'h00001013, 0, 0, 0, 4, 6, 1, 1, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0};
        v[9]  = '{32'h12345037, 0, 0, 0, 4, 0, 0, 0, 1, 0, 0, 0, 0, 4, 0, 0, 0, 0};
        v[10] = '{32'h00002003, 0, 0, 2, 7, 0, 1, 1, 0, 0, 0, 0, 0, 7, 1, 3, 0, 0};
        v[11] = '{32'h00002023, 0, 0, 0, 4, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        v[12] = '{32'h00002023, 0, 0, 1, 5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0};
        v[13] = '{32'h00000063, 1, 0, 0, 3, 1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0};
        v[14] = '{32'h00000063, 0, 0, 0, 3, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        v[15] = '{32'h00005063, 0, 1, 0, 3, 1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0};
        v[16] = '{32'h00000063, 0, 1, 0, 3, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        v[17] = '{32'h0000007F, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2};
        v[18] = '{32'h00000073, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        v[19] = '{32'h00003033, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2};
        v[20] = '{32'h00002023, 0, 0, 99, 8, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 3};

        rst = 1'b1; start = 1'b0; zero = 1'b0; greater_than = 1'b0; mem_ready = 1'b0;
        Instruction = 32'h00000033;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_halted", int'(halted), 0);
        check("reset_ir_en", int'(ir_en), 0);
        check("reset_pc_en", int'(pc_en), 0);
        check("reset_regwrite", int'(RegWrite), 0);
        check("reset_err", int'(err_code), 0);
        check("reset_retired", int'(retired_count), 0);
        rst = 1'b0;

        // reset asserted in the middle of an ADD's EXEC cycle
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("mid_rst_fetch", int'(ir_en), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_rst_exec_srca", int'(ALUSrcA), 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_regwrite", int'(RegWrite), 0);
        check("mid_rst_pc_en", int'(pc_en), 0);
        check("mid_rst_retired", int'(retired_count), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_after_rst", int'(busy), 0);
        check("idle_no_regwrite", int'(RegWrite), 0);

        Instruction = v[0].ins;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 21; i++) begin
            row = i;
            run_row(v[i]);
            if (v[i].err != 0) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                check("restart_err_clear", int'(err_code), 0);
                check("restart_fetch", int'(ir_en), 1);
                check("restart_not_halted", int'(halted), 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
